// File: rtl/fluid_seq_ctrl.sv
// Valve/pump sequencer: PRIME1 -> PRIME2 -> PRIME3 -> MIX -> DRAIN -> DONE, zero-length phases skipped.
// Optional `abort` input when FLUID_SEQ_ABORT_EN is defined; all outputs are registered.
module fluid_seq_ctrl #(
   parameter int CNT_W    = 16,
   parameter int PUMP_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] t_soln1,
   input  logic [CNT_W-1:0] t_soln2,
   input  logic [CNT_W-1:0] t_soln3,
   input  logic [CNT_W-1:0] t_mix,
   input  logic [CNT_W-1:0] t_drain,
   output logic             valve_soln1,
   output logic             valve_soln2,
   output logic             valve_soln3,
   output logic             valve_out,
   output logic [2:0]       pump_ph,
   output logic             busy,
   output logic             done
`ifdef FLUID_SEQ_ABORT_EN
   ,
   input  logic             abort
`endif
);
   localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRIME1 = 3'd1,
      PRIME2 = 3'd2,
      PRIME3 = 3'd3,
      MIX    = 3'd4,
      DRAIN  = 3'd5,
      DONE   = 3'd6
   } state_t;

   state_t                state, nxt;
   logic [4:0][CNT_W-1:0] lat, src;
   logic [CNT_W-1:0]      cnt, nxt_cnt;
   logic [DIV_W-1:0]      div;
   logic                  accept, in_phase;

   assign accept   = cmd_valid && cmd_ready;
   assign in_phase = (state != IDLE) && (state != DONE);

   // Phase encodings 1..5 map onto count slots 0..4, so the next phase is
   // the lowest nonzero slot above the current state.
   always_comb begin
      src = accept ? {t_drain, t_mix, t_soln3, t_soln2, t_soln1} : lat;
      nxt = state;
      if ((state == IDLE && accept) || (in_phase && cnt == '0)) begin
         nxt = DONE;
         for (int i = 4; i >= 0; i--) begin
            if (src[i] != '0 && (i + 1) > int'(state))
               nxt = state_t'(3'(i + 1));
         end
      end else if (state == DONE) begin
         nxt = IDLE;
      end
`ifdef FLUID_SEQ_ABORT_EN
      if (in_phase && abort)
         nxt = DONE;
`endif
      nxt_cnt = (cnt != '0) ? cnt - CNT_W'(1) : '0;
      if (nxt != state) begin
         nxt_cnt = '0;
         for (int i = 0; i < 5; i++) begin
            if (int'(nxt) == i + 1)
               nxt_cnt = src[i] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         lat         <= '0;
         cnt         <= '0;
         div         <= '0;
         valve_soln1 <= 1'b0;
         valve_soln2 <= 1'b0;
         valve_soln3 <= 1'b0;
         valve_out   <= 1'b0;
         pump_ph     <= 3'b000;
         busy        <= 1'b0;
         done        <= 1'b0;
         cmd_ready   <= 1'b1;
      end else begin
         state       <= nxt;
         cnt         <= nxt_cnt;
         if (accept)
            lat <= src;
         valve_soln1 <= (nxt == PRIME1);
         valve_soln2 <= (nxt == PRIME2);
         valve_soln3 <= (nxt == PRIME3);
         valve_out   <= (nxt == DRAIN);
         busy        <= (nxt != IDLE) && (nxt != DONE);
         done        <= (nxt == DONE);
         cmd_ready   <= (nxt == IDLE);
         if (nxt != DRAIN) begin
            pump_ph <= 3'b000;
            div     <= '0;
         end else if (state != DRAIN) begin
            pump_ph <= 3'b001;
            div     <= '0;
         end else if (div == DIV_W'(PUMP_DIV - 1)) begin
            pump_ph <= {pump_ph[1:0], pump_ph[2]};
            div     <= '0;
         end else begin
            div <= div + DIV_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_fluid_seq_ctrl.sv
// Bench for fluid_seq_ctrl: per-cycle comparison against a queue-based model of the
// expected output trace, plus directed timing/reset checks and randomized commands.
module tb_fluid_seq_ctrl;
   localparam int CNT_W    = 16;
   localparam int PUMP_DIV = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic [CNT_W-1:0] t_soln1 = '0, t_soln2 = '0, t_soln3 = '0, t_mix = '0, t_drain = '0;
   logic             cmd_ready, valve_soln1, valve_soln2, valve_soln3, valve_out, busy, done;
   logic [2:0]       pump_ph;
`ifdef FLUID_SEQ_ABORT_EN
   logic             abort = 1'b0;
`endif

   fluid_seq_ctrl #(.CNT_W(CNT_W), .PUMP_DIV(PUMP_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .t_soln1(t_soln1), .t_soln2(t_soln2), .t_soln3(t_soln3), .t_mix(t_mix), .t_drain(t_drain),
      .valve_soln1(valve_soln1), .valve_soln2(valve_soln2), .valve_soln3(valve_soln3),
      .valve_out(valve_out), .pump_ph(pump_ph), .busy(busy), .done(done)
`ifdef FLUID_SEQ_ABORT_EN
      , .abort(abort)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       v1, v2, v3, vo;
      logic [2:0] pump;
      logic       busy, done, ready;
   } obs_t;

   obs_t q[$];
   obs_t exp_cur;
   int   n_chk = 0, n_fail = 0, cyc = 0, acc_edge = 0, done_gap = -1;

   function automatic obs_t idle_obs();
      obs_t o = '0;
      o.ready = 1'b1;
      return o;
   endfunction

   function automatic obs_t done_obs();
      obs_t o = '0;
      o.done = 1'b1;
      return o;
   endfunction

   function automatic obs_t dut_obs();
      return {valve_soln1, valve_soln2, valve_soln3, valve_out, pump_ph, busy, done, cmd_ready};
   endfunction

   // Expected trace of one command: each phase contributes its dwell count of cycles.
   function automatic void build(input int a, input int b, input int c, input int d, input int e);
      int t[5];
      obs_t o;
      t = '{a, b, c, d, e};
      for (int p = 0; p < 5; p++) begin
         for (int j = 0; j < t[p]; j++) begin
            o = '0;
            o.busy = 1'b1;
            if (p == 0) o.v1 = 1'b1;
            if (p == 1) o.v2 = 1'b1;
            if (p == 2) o.v3 = 1'b1;
            if (p == 4) begin
               o.vo   = 1'b1;
               o.pump = 3'(1 << ((j / PUMP_DIV) % 3));
            end
            q.push_back(o);
         end
      end
      q.push_back(done_obs());
   endfunction

   function automatic void chk_obs(input string nm, input obs_t act, input obs_t req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%b required=%b (v1 v2 v3 vo pump busy done ready)",
                  nm, cyc, act, req);
      end
   endfunction

   function automatic void chk_int(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endfunction

   function automatic int rt();
      return ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6));
   endfunction

   // One cycle: compare at negedge, then drive the inputs for the coming edge and advance the model.
   task automatic tick(input logic v, input int a, input int b, input int c, input int d,
                       input int e, input logic ab);
      @(negedge clk);
      cyc++;
      chk_obs("trace", dut_obs(), exp_cur);
      if (done === 1'b1) done_gap = cyc - acc_edge;
      cmd_valid = v;
      t_soln1 = CNT_W'(a); t_soln2 = CNT_W'(b); t_soln3 = CNT_W'(c);
      t_mix = CNT_W'(d); t_drain = CNT_W'(e);
`ifdef FLUID_SEQ_ABORT_EN
      abort = ab;
      if (ab && exp_cur.busy) begin
         q.delete();
         q.push_back(done_obs());
      end
`endif
      if (exp_cur.ready && v && rst_n) begin
         q.delete();
         build(a, b, c, d, e);
         acc_edge = cyc + 1;
      end
      exp_cur = (q.size() != 0) ? q.pop_front() : idle_obs();
   endtask

   task automatic garbage_tick(input logic ab);
      tick(1'b1, rt(), rt(), rt(), rt(), rt(), ab);
   endtask

   task automatic run_cmd(input int a, input int b, input int c, input int d, input int e);
      tick(1'b1, a, b, c, d, e, 1'b0);
      for (int i = 0; i < 200 && !exp_cur.ready; i++) garbage_tick(1'b0);
      if (!exp_cur.ready) chk_int("timeout", 0, 1);
      tick(1'b0, 0, 0, 0, 0, 0, 1'b0);
   endtask

   initial begin
      int pump_req[7];
      exp_cur = idle_obs();

      build(3, 2, 4, 5, 6);
      chk_int("model_len", q.size(), 21);
      chk_int("model_first_v1", int'(q[0].v1), 1);
      chk_int("model_v2_start", int'(q[3].v2), 1);
      chk_int("model_last_vo", int'(q[19].vo), 1);
      chk_int("model_done", int'(q[20].done), 1);
      q.delete();
      build(0, 0, 0, 0, 7);
      pump_req = '{1, 1, 2, 2, 4, 4, 1};
      for (int i = 0; i < 7; i++) chk_int("model_pump", int'(q[i].pump), pump_req[i]);
      chk_int("model_pump_after", int'(q[7].pump), 0);
      q.delete();

      repeat (3) tick(1'b0, 0, 0, 0, 0, 0, 1'b0);
      rst_n = 1'b1;
      tick(1'b0, 0, 0, 0, 0, 0, 1'b0);

      done_gap = -1;
      run_cmd(3, 2, 4, 5, 6);
      chk_int("gap_main", done_gap, 20);
      done_gap = -1;
      run_cmd(0, 2, 0, 0, 3);
      chk_int("gap_skip", done_gap, 5);
      done_gap = -1;
      run_cmd(0, 0, 0, 0, 0);
      chk_int("gap_zero", done_gap, 0);
      run_cmd(0, 0, 0, 0, 7);

      // Reset asserted mid-cycle during the 7th DRAIN cycle.
      tick(1'b1, 0, 0, 0, 0, 10, 1'b0);
      repeat (7) garbage_tick(1'b0);
      #2 rst_n = 1'b0;
      #1 chk_obs("reset_async", dut_obs(), idle_obs());
      q.delete();
      exp_cur = idle_obs();
      repeat (2) tick(1'b0, 0, 0, 0, 0, 0, 1'b0);
      rst_n = 1'b1;
      tick(1'b0, 0, 0, 0, 0, 0, 1'b0);
      chk_int("ready_after_reset", int'(cmd_ready), 1);

`ifdef FLUID_SEQ_ABORT_EN
      tick(1'b1, 0, 0, 0, 4, 3, 1'b0);
      tick(1'b0, 0, 0, 0, 0, 0, 1'b0);
      tick(1'b0, 0, 0, 0, 0, 0, 1'b1);
      tick(1'b0, 0, 0, 0, 0, 0, 1'b0);
      chk_int("abort_done", int'(done), 1);
      tick(1'b0, 0, 0, 0, 0, 0, 1'b0);
      chk_int("abort_ready", int'(cmd_ready), 1);
`endif

      for (int i = 0; i < 1500; i++)
         tick(1'($urandom_range(0, 1)), rt(), rt(), rt(), rt(), rt(),
              1'($urandom_range(0, 15) == 0));
      tick(1'b0, 0, 0, 0, 0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fluid_seq_ctrl.md
# fluid_seq_ctrl

Clocked valve and pump sequencer that drives the soln1/soln2/soln3 inlet valves and the output drain of a two-stage serpentine/diffmix mixing network. It loads a command of per-phase dwell times through a valid/ready handshake. It then runs the inlet-priming, mix-settle and drain phases in a fixed order, and pulses `done` when the drain phase finishes. It sits between the host command interface and the chip's pneumatic valve drivers. It is the control side of the passive fluidic netlist it feeds.

## Interface
Parameters:
- `CNT_W`, 16: width of every dwell-time field and of the phase counter.
- `PUMP_DIV`, 4: number of clock cycles each peristaltic pump phase is held during drain; legal range is 1 or more.

Ports:
- `clk`  in  1  single system clock; all logic uses its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  a command is present on the dwell-time inputs.
- `cmd_ready`  out  1  block is idle and will accept a command.
- `t_soln1`, `t_soln2`, `t_soln3`  in  `CNT_W` each  inlet-open dwell time for each solution, in cycles.
- `t_mix`  in  `CNT_W`  settle time with all valves closed, in cycles.
- `t_drain`  in  `CNT_W`  drain time, in cycles.
- `valve_soln1`, `valve_soln2`, `valve_soln3`  out  1 each  inlet valve open.
- `valve_out`  out  1  outlet valve open.
- `pump_ph`  out  3  one-hot peristaltic pump phase.
- `busy`  out  1  a sequence is in progress.
- `done`  out  1  one-cycle pulse marking the end of a sequence.
- `abort`  in  1  present only when `FLUID_SEQ_ABORT_EN` is defined.

## Operation
- States: IDLE → PRIME1 → PRIME2 → PRIME3 → MIX → DRAIN → DONE → IDLE.
- IDLE: `cmd_ready`=1. A handshake completes on a cycle with `cmd_valid` && `cmd_ready`. On that edge all five dwell times are latched. Later changes on the inputs have no effect until the next accept.
- Phase advance: from the current state, the next state is the next phase whose latched count is nonzero. Zero-count phases are skipped with no cycle spent in them. If all five counts are zero, the next state after accept is DONE.
- A phase with count N occupies exactly N cycles. The down-counter loads N−1 on entry, and the state advances on the cycle in which the counter reads 0.
- Valve outputs are registered and decoded from the state:
  - `valve_soln1` is high only in PRIME1, `valve_soln2` only in PRIME2, `valve_soln3` only in PRIME3.
  - `valve_out` is high only in DRAIN.
  - At most one valve is open on any cycle.
- Pump: active only in DRAIN. On entry to DRAIN, `pump_ph`=3'b001. It rotates 001→010→100→001 every `PUMP_DIV` cycles. Outside DRAIN it is 3'b000, and its divider is reset on every DRAIN entry.
- DONE: lasts exactly one cycle. `done`=1 and `busy`=0 during DONE, then the state returns to IDLE.
- `busy` is 1 in PRIME1 through DRAIN.
- `cmd_ready` is 0 in every state except IDLE, so `cmd_valid` outside IDLE is ignored.
- Reset, whether at power-up or mid-sequence: state goes to IDLE immediately. All valves are closed, `pump_ph`=0, `busy`=0, `done`=0, `cmd_ready`=1 after reset, and the counters are cleared. The latched command is discarded.

## Timing
- If accept occurs on edge k, the first phase output is high starting on the cycle after edge k.
- Total cycles from accept to the `done` pulse = t_soln1 + t_soln2 + t_soln3 + t_mix + t_drain. `done` is asserted on the cycle immediately after the last active phase cycle.
- The earliest next accept is the cycle after `done`, so back-to-back commands have a one-cycle DONE gap plus one IDLE cycle.
- No combinational path runs from any input to any output. `cmd_ready` is registered from the state.

## Configuration
- `FLUID_SEQ_ABORT_EN` defined:
  - The `abort` input exists.
  - `abort`=1, sampled in PRIME1..DRAIN, moves the state to DONE on the next edge. All valves close and `pump_ph`=0 on that edge.
  - `done` pulses for one cycle, and the remaining phases are not run.
  - `abort` in IDLE or DONE is ignored.
- Not defined: the `abort` port is absent, and every accepted sequence runs to completion unless reset.

## Test plan
- Reset with `rst_n`=0 during DRAIN at cycle 7 → the same cycle shows all valves 0, `pump_ph`=0, `busy`=0. After release, `cmd_ready`=1.
- Accept t=(3,2,4,5,6) → `valve_soln1` high 3 cycles, then `valve_soln2` 2, `valve_soln3` 4, all closed 5, `valve_out` 6. `done` pulses 20 cycles after accept.
- Accept t=(0,2,0,0,3) → PRIME1, PRIME3 and MIX are skipped. `valve_soln2` is high for 2 cycles, then `valve_out` for 3, then `done`.
- All counts zero → `done` pulses on the cycle after accept, with no valve ever asserted.
- With `PUMP_DIV`=2 and t_drain=7 → `pump_ph` sequence is 001,001,010,010,100,100,001, then 000.
- With `FLUID_SEQ_ABORT_EN` defined: `abort` during the 2nd MIX cycle → valves and pump go to 0 on the next edge, `done` pulses once, `cmd_ready`=1 the following cycle. `valve_out` is never asserted.
